// File: rtl/seg7_monitor_3digit.sv
// seg7_monitor_3digit: debounces three 7-segment digit buses, decodes them
// back to BCD, rebuilds a 0..999 value and checks it advances by +1 mod 1000.
// Latency: pattern stable from sampling edge 0 -> accept at edge STABLE_CYCLES,
// outputs/pulses registered at edge STABLE_CYCLES+1. No backpressure (monitor only).
// Ports: clk, rst (sync, active-high); seg0/seg1/seg2 (bit7..1 = a..g, bit0 = dp);
//        digit0..2, value, value_valid, pattern_err, seq_err, err_count.
// Optional: define SEG7_LEADING_BLANK_EN to decode 00 on seg2 (and on seg1 when
//           seg2 is also 00) as digit 0.
module seg7_monitor_3digit #(
  parameter int STABLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seg0,
  input  logic [7:0]       seg1,
  input  logic [7:0]       seg2,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [9:0]       value,
  output logic             value_valid,
  output logic             pattern_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

  typedef enum logic {WAIT_FIRST, TRACK} state_t;

  // Returns {valid, bcd}. blank_ok lets an all-dark digit read as 0.
  function automatic logic [4:0] dec(input logic [7:0] p, input logic blank_ok);
    logic [4:0] r;
    r = 5'd0;
    case (p)
      8'hFC: r = {1'b1, 4'd0};
      8'h60: r = {1'b1, 4'd1};
      8'hDA: r = {1'b1, 4'd2};
      8'hF2: r = {1'b1, 4'd3};
      8'h66: r = {1'b1, 4'd4};
      8'hB6: r = {1'b1, 4'd5};
      8'hBE: r = {1'b1, 4'd6};
      8'hE0: r = {1'b1, 4'd7};
      8'hFE: r = {1'b1, 4'd8};
      8'hE6: r = {1'b1, 4'd9};
      8'h00: r = {blank_ok, 4'd0};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // dp bits are forced low so they never disturb debounce or decode
  logic [23:0] w_bus;
  assign w_bus = {seg2, seg1, seg0} & 24'hFEFEFE;

  logic [23:0] r_samp;
  logic [23:0] r_last;
  logic [3:0]  r_stab_cnt;
  logic        r_acc;
  state_t      r_state;

  logic [3:0] w_cnt_next;
  always_comb begin
    w_cnt_next = r_stab_cnt;
    if (w_bus != r_samp)
      w_cnt_next = 4'd0;
    else if (r_stab_cnt != STAB)
      w_cnt_next = r_stab_cnt + 4'd1;
  end

  logic w_blank1;
  logic w_blank2;
`ifdef SEG7_LEADING_BLANK_EN
  assign w_blank2 = 1'b1;
  assign w_blank1 = (r_samp[23:16] == 8'h00);
`else
  assign w_blank2 = 1'b0;
  assign w_blank1 = 1'b0;
`endif

  logic [4:0] w_dec0;
  logic [4:0] w_dec1;
  logic [4:0] w_dec2;
  assign w_dec0 = dec(r_samp[7:0],   1'b0);
  assign w_dec1 = dec(r_samp[15:8],  w_blank1);
  assign w_dec2 = dec(r_samp[23:16], w_blank2);

  logic       w_all_valid;
  logic [9:0] w_new_value;
  logic [9:0] w_exp_value;
  assign w_all_valid = w_dec0[4] & w_dec1[4] & w_dec2[4];
  assign w_new_value = 10'(w_dec2[3:0]) * 10'd100 + 10'(w_dec1[3:0]) * 10'd10
                     + 10'(w_dec0[3:0]);
  assign w_exp_value = (value == 10'd999) ? 10'd0 : value + 10'd1;

  logic w_err_sat;
  assign w_err_sat = (err_count == {ERR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp      <= '0;
      r_last      <= '0;
      r_stab_cnt  <= '0;
      r_acc       <= 1'b0;
      r_state     <= WAIT_FIRST;
      digit0      <= '0;
      digit1      <= '0;
      digit2      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      r_samp     <= w_bus;
      r_stab_cnt <= w_cnt_next;
      // Single-cycle accept strobe on the edge the counter first reaches the target
      r_acc      <= (w_cnt_next == STAB) && (r_stab_cnt != STAB);

      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;

      // Re-settling on the already-accepted pattern (glitch) is ignored
      if (r_acc && (r_samp != r_last)) begin
        r_last <= r_samp;
        if (!w_all_valid) begin
          pattern_err <= 1'b1;
          if (!w_err_sat) err_count <= err_count + 1'b1;
        end else begin
          digit0      <= w_dec0[3:0];
          digit1      <= w_dec1[3:0];
          digit2      <= w_dec2[3:0];
          value       <= w_new_value;
          value_valid <= 1'b1;
          r_state     <= TRACK;
          if ((r_state == TRACK) && (w_new_value != w_exp_value)) begin
            seq_err <= 1'b1;
            if (!w_err_sat) err_count <= err_count + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_monitor_3digit.sv
// Scoreboard bench for seg7_monitor_3digit: directed digit patterns, expected
// events queued at stimulus time, checked by an independent output monitor.
module tb_seg7_monitor_3digit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg0, seg1, seg2;
  logic [3:0] digit0, digit1, digit2;
  logic [9:0] value;
  logic       value_valid, pattern_err, seq_err;
  logic [7:0] err_count;

  seg7_monitor_3digit #(.STABLE_CYCLES(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .value(value),
    .value_valid(value_valid), .pattern_err(pattern_err), .seq_err(seq_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vv;
    logic       pe;
    logic       se;
    logic [9:0] val;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [7:0] err;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  logic [7:0] SEG [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                           8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};

  function automatic ev_t mk(input logic vv, input logic pe, input logic se,
                             input int v, input int err);
    ev_t e;
    e.vv  = vv;
    e.pe  = pe;
    e.se  = se;
    e.val = 10'(v);
    e.d2  = 4'(v / 100);
    e.d1  = 4'((v / 10) % 10);
    e.d0  = 4'(v % 10);
    e.err = 8'(err);
    return e;
  endfunction

  function automatic ev_t cur();
    ev_t e;
    e.vv  = value_valid;
    e.pe  = pattern_err;
    e.se  = seq_err;
    e.val = value;
    e.d2  = digit2;
    e.d1  = digit1;
    e.d0  = digit0;
    e.err = err_count;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a decimal value (dp optional) and hold it for n cycles
  task automatic show(input int v, input int n, input logic dp);
    seg2 = SEG[v / 100]        | {7'd0, dp};
    seg1 = SEG[(v / 10) % 10]  | {7'd0, dp};
    seg0 = SEG[v % 10]         | {7'd0, dp};
    repeat (n) tick();
  endtask

  task automatic do_reset(input string name, input int n);
    ev_t g;
    seg0 = 8'h00;
    seg1 = 8'h00;
    seg2 = 8'h00;
    rst  = 1'b1;
    repeat (n) tick();
    g = cur();
    total++;
    if (g !== '0) begin
      bad++;
      $display("FAIL %s got=%h required=0", name, g);
    end
    rst = 1'b0;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  initial begin
    ev_t g, e;
    forever begin
      @(negedge clk);
      if (value_valid || pattern_err || seq_err) begin
        g = cur();
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got=%h required=no_event", g);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL event got=%h required=%h", g, e);
          end
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    seg0 = 8'h00;
    seg1 = 8'h00;
    seg2 = 8'h00;
    do_reset("reset_init", 3);

    // 1: first value, then a long hold must not re-fire
    q.push_back(mk(1, 0, 0, 0, 0));
    show(0, 24, 1'b0);

    // 2: wrap through 999 -> 000
    do_reset("reset_t2", 2);
    q.push_back(mk(1, 0, 0, 998, 0)); show(998, 6, 1'b0);
    q.push_back(mk(1, 0, 0, 999, 0)); show(999, 6, 1'b0);
    q.push_back(mk(1, 0, 0, 0,   0)); show(0,   6, 1'b0);
    q.push_back(mk(1, 0, 0, 1,   0)); show(1,   6, 1'b0);

    // 3: skip 006 -> sequence error, then normal step
    do_reset("reset_t3", 2);
    q.push_back(mk(1, 0, 0, 5, 0)); show(5, 6, 1'b0);
    q.push_back(mk(1, 0, 1, 7, 1)); show(7, 6, 1'b0);
    q.push_back(mk(1, 0, 0, 8, 1)); show(8, 6, 1'b0);

    // 4: illegal tens pattern, then recovery to 011
    do_reset("reset_t4", 2);
    q.push_back(mk(1, 0, 0, 10, 0)); show(10, 6, 1'b0);
    q.push_back(mk(0, 1, 0, 10, 1));
    seg1 = 8'h12;
    repeat (8) tick();
    q.push_back(mk(1, 0, 0, 11, 1)); show(11, 6, 1'b0);

    // 5: one-cycle glitch and dp toggling are silent; 001 still in sequence
    do_reset("reset_t5", 2);
    q.push_back(mk(1, 0, 0, 0, 0)); show(0, 6, 1'b0);
    seg0 = 8'h60;
    tick();
    show(0, 8, 1'b0);
    for (int i = 0; i < 10; i++) show(0, 1, 1'(i % 2 == 0));
    q.push_back(mk(1, 0, 0, 1, 0)); show(1, 6, 1'b0);

    // 6: reset at 123 returns to WAIT_FIRST
    q.push_back(mk(1, 0, 1, 123, 1)); show(123, 6, 1'b0);
    do_reset("reset_t6", 1);
    q.push_back(mk(1, 0, 0, 500, 0)); show(500, 6, 1'b0);

    repeat (10) tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got=%0d_pending required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
